// File: rtl/poli_crc_engine.sv
// Parametrised multi-cycle CRC engine behind a four-register word interface.
// Optional macro POLI_CRC_REFLECT_EN: LSB-first input and bit-reversed OUTPUT (reflected CRCs).
module poli_crc_engine #(
    parameter int          CRC_WIDTH      = 32,
    parameter logic [31:0] POLY           = 32'h04C11DB7,
    parameter logic [31:0] INIT           = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT        = 32'h00000000,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] A_CONTROL = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_INPUT   = 2'd2;
    localparam logic [1:0] A_OUTPUT  = 2'd3;
    localparam logic [4:0] CNT_LOAD  = 5'(32 / BITS_PER_CYCLE - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [4:0]            cnt;
    logic [CRC_WIDTH-1:0]  rem;
    logic [CRC_WIDTH-1:0]  rem_next;
    logic [CRC_WIDTH-1:0]  rem_out;
    logic [31:0]           shreg;
    logic [31:0]           out_word;
    logic [BITS_PER_CYCLE-1:0] din;
    logic                  irq_en;
    logic                  done;
    logic                  overrun;
    logic                  busy;
    logic                  wr_ctrl;
    logic                  wr_stat;
    logic                  wr_in;
    logic                  clr;

    // Processes din[BITS_PER_CYCLE-1] first, down to din[0].
    function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] r,
                                                      input logic [BITS_PER_CYCLE-1:0] d);
        logic [CRC_WIDTH-1:0] t;
        logic                 fb;
        t = r;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            fb = t[CRC_WIDTH-1] ^ d[i];
            t  = {t[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY[CRC_WIDTH-1:0] : '0);
        end
        return t;
    endfunction

`ifdef POLI_CRC_REFLECT_EN
    function automatic logic [CRC_WIDTH-1:0] bit_rev(input logic [CRC_WIDTH-1:0] x);
        logic [CRC_WIDTH-1:0] y;
        for (int i = 0; i < CRC_WIDTH; i++) y[i] = x[CRC_WIDTH-1-i];
        return y;
    endfunction
`endif

    assign busy    = (state == SHIFT);
    assign wr_ctrl = wen && (addr == A_CONTROL);
    assign wr_stat = wen && (addr == A_STATUS);
    assign wr_in   = wen && (addr == A_INPUT);
    assign clr     = wr_ctrl && wdata[0];
    assign irq     = done & irq_en;

    always_comb begin
        din = '0;
`ifdef POLI_CRC_REFLECT_EN
        for (int i = 0; i < BITS_PER_CYCLE; i++) din[BITS_PER_CYCLE-1-i] = shreg[i];
`else
        din = shreg[31 -: BITS_PER_CYCLE];
`endif
    end

    assign rem_next = crc_step(rem, din);

`ifdef POLI_CRC_REFLECT_EN
    assign rem_out = bit_rev(rem) ^ XOR_OUT[CRC_WIDTH-1:0];
`else
    assign rem_out = rem ^ XOR_OUT[CRC_WIDTH-1:0];
`endif

    always_comb begin
        out_word = '0;
        out_word[CRC_WIDTH-1:0] = rem_out;
        rdata = '0;
        if (ren) begin
            case (addr)
                A_CONTROL: rdata = {30'd0, irq_en, 1'b0};
                A_STATUS:  rdata = {29'd0, overrun, done, busy};
                A_INPUT:   rdata = '0;
                A_OUTPUT:  rdata = out_word;
                default:   rdata = '0;
            endcase
        end
    end

    // Control FSM; a DONE set on the final shift overrides a same-cycle W1C.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= INIT[CRC_WIDTH-1:0];
            irq_en  <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= wdata[1];
            if (wr_stat && wdata[2]) overrun <= 1'b0;
            if (wr_in && state == SHIFT) overrun <= 1'b1;
            if (wr_stat && wdata[1]) done <= 1'b0;

            if (clr) begin
                state <= IDLE;
                rem   <= INIT[CRC_WIDTH-1:0];
            end else if (state == IDLE) begin
                if (wr_in) begin
                    state <= SHIFT;
                    cnt   <= CNT_LOAD;
                    done  <= 1'b0;
                end
            end else begin
                rem <= rem_next;
                if (cnt == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Data word shifter carries no reset; it is always loaded before use.
    always_ff @(posedge CLK) begin
        if (state == IDLE && wr_in) begin
            shreg <= wdata;
        end else if (state == SHIFT) begin
`ifdef POLI_CRC_REFLECT_EN
            shreg <= shreg >> BITS_PER_CYCLE;
`else
            shreg <= shreg << BITS_PER_CYCLE;
`endif
        end
    end

endmodule

// File: tb/tb_poli_crc_engine.sv
// Directed bench for poli_crc_engine: CRC-8 (poly 07, init 0) at 1 and 8 bits per cycle.
module tb_poli_crc_engine;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wen   [2];
    logic        ren   [2];
    logic [1:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        irq   [2];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    poli_crc_engine #(.CRC_WIDTH(8), .POLY(32'h07), .INIT(32'h0), .XOR_OUT(32'h0),
                      .BITS_PER_CYCLE(1)) dut0 (
        .CLK(CLK), .nRST(nRST), .wen(wen[0]), .ren(ren[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .irq(irq[0]));

    poli_crc_engine #(.CRC_WIDTH(8), .POLY(32'h07), .INIT(32'h0), .XOR_OUT(32'h0),
                      .BITS_PER_CYCLE(8)) dut1 (
        .CLK(CLK), .nRST(nRST), .wen(wen[1]), .ren(ren[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .irq(irq[1]));

    task automatic write(input int u, input logic [1:0] a, input logic [31:0] d);
        @(negedge CLK);
        wen[u] = 1'b1; addr[u] = a; wdata[u] = d;
        @(negedge CLK);
        wen[u] = 1'b0; wdata[u] = '0;
    endtask

    task automatic rd(input int u, input logic [1:0] a, output logic [31:0] v);
        addr[u] = a; ren[u] = 1'b1;
        #1 v = rdata[u];
        ren[u] = 1'b0;
    endtask

    task automatic run_word(input int u, input logic [31:0] d, output int cyc);
        logic [31:0] s;
        write(u, 2'd2, d);
        cyc = 0;
        rd(u, 2'd1, s);
        while (s[0] && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            rd(u, 2'd1, s);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int u = 0; u < 2; u++) begin
            rd(u, 2'd1, v);
            tests++;
            if (v !== 32'h0) begin fails++; $display("FAIL reset_status u%0d: got %h want %h", u, v, 32'h0); end
            rd(u, 2'd3, v);
            tests++;
            if (v !== 32'h0) begin fails++; $display("FAIL reset_output u%0d: got %h want %h", u, v, 32'h0); end
            tests++;
            if (irq[u] !== 1'b0) begin fails++; $display("FAIL reset_irq u%0d: got %b want 0", u, irq[u]); end
        end
    endtask

    task automatic test_basic;
        logic [31:0] v;
        int cyc;
        write(0, 2'd0, 32'h1);
        rd(0, 2'd0, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL ctrl_clear_reads0: got %h want %h", v, 32'h0); end
        run_word(0, 32'h00000001, cyc);
        tests++;
        if (cyc !== 32) begin fails++; $display("FAIL busy_cycles_bpc1: got %0d want 32", cyc); end
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL done_status: got %h want %h", v, 32'h2); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h07) begin fails++; $display("FAIL crc_0001: got %h want %h", v, 32'h07); end
        write(0, 2'd0, 32'h1);
        run_word(0, 32'h00000080, cyc);
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL crc_0080: got %h want %h", v, 32'h89); end
        rd(0, 2'd2, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL input_reads0: got %h want %h", v, 32'h0); end
        write(0, 2'd3, 32'hFF);
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL output_write_ignored: got %h want %h", v, 32'h89); end
        addr[0] = 2'd3; ren[0] = 1'b0;
        #1;
        tests++;
        if (rdata[0] !== 32'h0) begin fails++; $display("FAIL rdata_ren_low: got %h want %h", rdata[0], 32'h0); end
    endtask

    task automatic test_chain;
        logic [31:0] v;
        int cyc;
        write(0, 2'd0, 32'h1);
        run_word(0, 32'h00000001, cyc);
        run_word(0, 32'h00000000, cyc);
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h62) begin fails++; $display("FAIL chain: got %h want %h", v, 32'h62); end
    endtask

    task automatic test_throughput;
        logic [31:0] v;
        int cyc;
        write(1, 2'd0, 32'h1);
        run_word(1, 32'h00000080, cyc);
        tests++;
        if (cyc !== 4) begin fails++; $display("FAIL busy_cycles_bpc8: got %0d want 4", cyc); end
        rd(1, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL crc_bpc8: got %h want %h", v, 32'h89); end
        rd(1, 2'd1, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL status_bpc8: got %h want %h", v, 32'h2); end
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        int cyc;
        write(0, 2'd0, 32'h1);
        write(0, 2'd1, 32'h6);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL w1c_both: got %h want %h", v, 32'h0); end
        write(0, 2'd2, 32'h00000080);
        repeat (3) @(negedge CLK);
        write(0, 2'd2, 32'h12345678);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h5) begin fails++; $display("FAIL overrun_status: got %h want %h", v, 32'h5); end
        cyc = 0;
        rd(0, 2'd1, v);
        while (v[0] && cyc < 200) begin @(negedge CLK); cyc++; rd(0, 2'd1, v); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL overrun_output: got %h want %h", v, 32'h89); end
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h6) begin fails++; $display("FAIL overrun_done_status: got %h want %h", v, 32'h6); end
        write(0, 2'd1, 32'h4);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL overrun_w1c: got %h want %h", v, 32'h2); end
        // INPUT write on the edge where the last shift completes
        write(0, 2'd0, 32'h1);
        write(0, 2'd2, 32'h00000080);
        repeat (30) @(negedge CLK);
        write(0, 2'd2, 32'hDEADBEEF);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h6) begin fails++; $display("FAIL overrun_last_edge: got %h want %h", v, 32'h6); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL overrun_last_edge_out: got %h want %h", v, 32'h89); end
    endtask

    task automatic test_irq;
        logic [31:0] v;
        write(0, 2'd1, 32'h6);
        write(0, 2'd0, 32'h2);
        rd(0, 2'd0, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL irq_en_read: got %h want %h", v, 32'h2); end
        tests++;
        if (irq[0] !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", irq[0]); end
        write(0, 2'd0, 32'h3);
        write(0, 2'd2, 32'h00000001);
        repeat (30) @(negedge CLK);
        tests++;
        if (irq[0] !== 1'b0) begin fails++; $display("FAIL irq_busy: got %b want 0", irq[0]); end
        write(0, 2'd1, 32'h2);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL done_set_wins: got %h want %h", v, 32'h2); end
        tests++;
        if (irq[0] !== 1'b1) begin fails++; $display("FAIL irq_with_done: got %b want 1", irq[0]); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h07) begin fails++; $display("FAIL irq_run_output: got %h want %h", v, 32'h07); end
        write(0, 2'd1, 32'h2);
        tests++;
        if (irq[0] !== 1'b0) begin fails++; $display("FAIL irq_w1c: got %b want 0", irq[0]); end
    endtask

    task automatic test_abort;
        logic [31:0] v;
        int cyc;
        write(0, 2'd0, 32'h1);
        write(0, 2'd2, 32'hFFFFFFFF);
        repeat (8) @(negedge CLK);
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'hF3) begin fails++; $display("FAIL partial_output: got %h want %h", v, 32'hF3); end
        write(0, 2'd0, 32'h1);
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL abort_status: got %h want %h", v, 32'h0); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL abort_output: got %h want %h", v, 32'h0); end
        run_word(0, 32'h00000080, cyc);
        tests++;
        if (cyc !== 32) begin fails++; $display("FAIL abort_rerun_cycles: got %0d want 32", cyc); end
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h89) begin fails++; $display("FAIL abort_rerun_output: got %h want %h", v, 32'h89); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int cyc;
        write(0, 2'd0, 32'h2);
        tests++;
        if (irq[0] !== 1'b1) begin fails++; $display("FAIL irq_before_reset: got %b want 1", irq[0]); end
        write(0, 2'd2, 32'hFFFFFFFF);
        repeat (5) @(negedge CLK);
        #2 nRST = 1'b0;
        rd(0, 2'd1, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL midreset_status: got %h want %h", v, 32'h0); end
        tests++;
        if (irq[0] !== 1'b0) begin fails++; $display("FAIL midreset_irq: got %b want 0", irq[0]); end
        rd(0, 2'd0, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL midreset_ctrl: got %h want %h", v, 32'h0); end
        @(negedge CLK);
        nRST = 1'b1;
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL midreset_output: got %h want %h", v, 32'h0); end
        run_word(0, 32'h00000001, cyc);
        rd(0, 2'd3, v);
        tests++;
        if (v !== 32'h07) begin fails++; $display("FAIL post_reset_crc: got %h want %h", v, 32'h07); end
    endtask

    initial begin
        nRST = 1'b0;
        for (int u = 0; u < 2; u++) begin
            wen[u] = 1'b0; ren[u] = 1'b0; addr[u] = 2'd0; wdata[u] = '0;
        end
        #2;
        test_reset;
        @(negedge CLK);
        nRST = 1'b1;
        test_basic;
        test_chain;
        test_throughput;
        test_overrun;
        test_irq;
        test_abort;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
